// File: rtl/fetch_pkg.sv
// Shared widths, reset defaults and the packet type for the fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_if.sv
// Valid/ready channel carrying fetched instructions from fetch to decode.
interface fetch_if;
  import fetch_pkg::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);

endinterface

// File: rtl/fetch_skid_buf.sv
// Output slot plus one-entry skid slot; keeps returning words in order while
// decode stalls, and drops everything on a flush.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  fetch_pkt_t pkt_in,
  input  logic       out_ready,
  output logic       out_valid,
  output fetch_pkt_t out_pkt,
  output logic       skid_valid
);

  fetch_pkt_t skid_pkt;
  logic       consume;

  // Decode takes the output word when both sides agree this cycle.
  always_comb begin
    consume = out_valid & out_ready;
  end

  // Refill the output from the skid first, then from the returning word; a
  // word that cannot reach the output parks in the skid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_pkt.instr  <= '0;
      out_pkt.pc     <= RESET_PC;
      skid_valid     <= 1'b0;
      skid_pkt.instr <= '0;
      skid_pkt.pc    <= RESET_PC;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume || !out_valid) begin
      if (skid_valid) begin
        out_pkt    <= skid_pkt;
        out_valid  <= 1'b1;
        skid_valid <= push;
        if (push) begin
          skid_pkt <= pkt_in;
        end
      end else if (push) begin
        out_pkt   <= pkt_in;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      skid_pkt   <= pkt_in;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word addresses to a
// 1-cycle synchronous memory and hands instructions to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rst,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_if.master         dec
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            out_valid;
  logic            skid_valid;
  logic            consume;
  logic [1:0]      occ;
  logic [1:0]      occ_after;
  logic            issue;
  logic            push_ret;
  fetch_pkt_t      ret_pkt;
  fetch_pkt_t      out_pkt;

  // Issue only when the word it returns is guaranteed a free slot, which
  // also means a return never lands on a full skid.
  always_comb begin
    consume   = out_valid & dec.ready;
    occ       = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight};
    occ_after = occ - {1'b0, consume};
    issue     = fetch_en & ~redirect_valid & (occ_after < 2'd2);
    push_ret  = inflight & ~redirect_valid;
    ret_pkt.instr = imem_instr;
    ret_pkt.pc    = inflight_pc;
    imem_addr = {2'b00, pc[XLEN-1:2]};
    imem_rst  = ~reset_n;
  end

  // PC and in-flight tracking; a redirect wins and drops the pending read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + PC_STEP;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_skid_buf #(.RESET_PC(RESET_PC)) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push_ret),
    .pkt_in     (ret_pkt),
    .out_ready  (dec.ready),
    .out_valid  (out_valid),
    .out_pkt    (out_pkt),
    .skid_valid (skid_valid)
  );

  // Present the output slot on the decode channel.
  always_comb begin
    dec.valid = out_valid;
    dec.instr = out_pkt.instr;
    dec.pc    = out_pkt.pc;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the program counter and drives the word address into the synchronous instruction memory.
- That memory has a 1-cycle registered read. Returned words are paired with their PC and presented to decode over a valid/ready interface.
- Branch/jump redirects from execute flush all in-flight and buffered fetches.
- A one-entry skid buffer absorbs decode backpressure, so steady state is 1 instr/cycle.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits[1:0] must be 0.
- XLEN, 32, PC/instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  1 = issue new fetches; 0 = stop issuing, in-flight still completes.
- imem_addr  out  XLEN  word index to instruction memory, = {2'b00, pc[XLEN-1:2]}; sampled by memory at clk edge.
- imem_instr  in  XLEN  memory read data, valid the cycle after the address edge.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  XLEN  new byte PC; bits[1:0] ignored (treated as 0).
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts this cycle.
- if_instr  out  XLEN  instruction word.
- if_pc  out  XLEN  byte PC of if_instr.

Behaviour:
- Reset (reset_n=0, async): pc=RESET_PC, imem_addr=RESET_PC>>2, if_valid=0, if_instr=0, if_pc=RESET_PC, skid empty, inflight=0.
- Top level drives memory reset from ~reset_n.
- State:
  - pc register.
  - inflight flag + inflight_pc: fetch issued last edge.
  - output slot: if_valid/if_instr/if_pc.
  - skid slot: valid/instr/pc.
- occ = if_valid + skid_valid + inflight; consume = if_valid & if_ready.
- issue = fetch_en & ~redirect_valid & (occ - consume < 2).
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 (wraps mod 2^XLEN).
  - Else: inflight<=0, pc holds.
- Return (inflight=1): imem_instr with inflight_pc goes to:
  - output slot, if the output is empty or consumed and the skid is empty;
  - otherwise the skid slot.
- When consume and skid_valid: skid moves to output; the returning word, if any, goes to skid. Order is always preserved.
- Never accept a return into a full skid; the issue rule guarantees this. The bench asserts it.
- Latency: fetch issued at edge N → if_valid earliest after edge N+1. First if_valid 2 edges after reset release, with if_ready=1.
- Throughput: 1 instr/cycle while if_ready=1 and fetch_en=1.
- redirect_valid=1 has highest priority, same cycle:
  - clear if_valid, skid and inflight; pc<={redirect_pc[XLEN-1:2],2'b00}; no issue that cycle.
  - The imem_instr returning that cycle is discarded.
  - Next cycle issues from redirect_pc.
  - A consume in the redirect cycle still counts as accepted by decode; decode owns that instruction's squash.
- Simultaneous redirect + fetch_en=0: flush and load pc, no issue.
- fetch_en falling: no new issue; outstanding return and buffers drain normally; if_pc/if_instr hold while if_valid=0.
- Holding: while if_valid=1 and if_ready=0, if_instr/if_pc stable.
- Reset mid-operation: immediate return to reset values; any pending memory read is ignored because inflight=0.

Decomposition:
- Package fetch_pkg: XLEN, RESET_PC default, PC_STEP=4, typedef fetch_pkt_t {instr, pc}.
- Sub-module fetch_skid_buf: output slot + skid slot + valid/ready logic, with push/pkt_in/flush ports.
- fetch_unit keeps pc, inflight and the issue rule.

Test Plan:
- Reset release, fetch_en=1, if_ready=1, image word0=0x00088893, word1=0x00a68693 → if_valid rises 2 edges after release with if_pc=0x0, if_instr=0x00088893; next cycle if_pc=0x4, if_instr=0x00a68693; then one instr per cycle.
- Hold if_ready=0 for 5 cycles mid-stream at if_pc=0x8 → if_instr/if_pc stable; imem_addr stops advancing after ≤2 buffered; resume → 0x8,0xC,0x10 in order, none lost or duplicated.
- redirect_valid=1, redirect_pc=0x14 while output and skid full → next cycle if_valid=0; following cycles deliver pc 0x14, 0x18 only.
- redirect_pc=0x1B → fetch restarts at 0x18.
- fetch_en=0 with one fetch in flight → that instruction is delivered, then if_valid=0 and pc frozen; fetch_en=1 resumes at the next sequential PC.
- Assert reset_n=0 mid-stream with if_valid=1 → if_valid=0 and imem_addr=0 immediately (async); after release, stream restarts at RESET_PC.
